// File: rtl/irq_cond_pkg.sv
// irq_cond_pkg: default parameters and mode encoding for the interrupt conditioner.
// PLIC_NUM_SOURCES normally arrives from the shared defines; the fallback covers standalone builds.
`ifndef PLIC_NUM_SOURCES
`define PLIC_NUM_SOURCES 4
`endif
package irq_cond_pkg;
    typedef enum logic {LEVEL = 1'b0, EDGE = 1'b1} irq_mode_e;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_STRETCH_CYCLES = 8;
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/irq_cond_chan.sv
// irq_cond_chan: one interrupt channel - synchronizer, glitch filter and optional pulse stretcher.
module irq_cond_chan
    import irq_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter irq_mode_e MODE = LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic en,
    output logic irq
);
    localparam int CW = cnt_width(FILTER_CYCLES);
    localparam int SW = cnt_width(STRETCH_CYCLES);
    logic [SYNC_STAGES-1:0] sync_q;
    logic sync, filt, filt_prev;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;
    assign sync = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
    // filt only follows sync after FILTER_CYCLES consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (FILTER_CYCLES == 0) begin
            filt <= sync;
            cnt  <= '0;
        end else if (sync == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    // a filt rise seen one cycle late (re)loads the stretch counter
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            filt_prev <= 1'b0;
            scnt      <= '0;
        end else begin
            filt_prev <= filt;
            scnt      <= (filt && !filt_prev) ? SW'(STRETCH_CYCLES) :
                         (scnt != '0)         ? scnt - 1'b1 : scnt;
        end
    end
    assign irq = (MODE == EDGE) ? (scnt != '0) : filt;
endmodule

// File: rtl/irq_conditioner.sv
// irq_conditioner: conditions asynchronous peripheral interrupt lines for the PLIC,
// one independent level- or edge-mode channel per source.
module irq_conditioner
    import irq_cond_pkg::*;
#(
    parameter int NUM_SRC = `PLIC_NUM_SOURCES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_raw,
    input  logic [NUM_SRC-1:0] src_en,
    output logic [NUM_SRC-1:0] irq_sources
);
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_chan
        irq_cond_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .STRETCH_CYCLES(STRETCH_CYCLES),
            .MODE(EDGE_MASK[i] ? EDGE : LEVEL)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .raw(irq_raw[i]),
            .en(src_en[i]),
            .irq(irq_sources[i])
        );
    end
endmodule

// File: tb/tb_irq_conditioner.sv
// tb_irq_conditioner: directed scenarios with a per-cycle expected-output scoreboard.
// Sources 0,1 are level mode, 2,3 edge mode; inputs change 1 time unit after an edge.
module tb_irq_conditioner;
    localparam int N = 4;
    localparam int END_CYC = 232;
    typedef struct {
        int   cyc;
        int   src;
        logic val;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] irq_raw = '0;
    logic [N-1:0] src_en = '1;
    logic [N-1:0] irq_sources;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    irq_conditioner #(
        .NUM_SRC(N),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(4),
        .STRETCH_CYCLES(8),
        .EDGE_MASK(4'b1100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_raw(irq_raw),
        .src_en(src_en),
        .irq_sources(irq_sources)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // expect src high for cycles hlo..hhi and low elsewhere in lo..hi
    task automatic exp_range(input int src, input int lo, input int hi, input int hlo, input int hhi);
        for (int c = lo; c <= hi; c++) sb.push_back('{c, src, logic'(c >= hlo && c <= hhi)});
    endtask

    task automatic check_now();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                assert (irq_sources[sb[i].src] === sb[i].val) else begin
                    errors++;
                    $error("FAIL src%0d cyc%0d: got %b expected %b", sb[i].src, cyc, irq_sources[sb[i].src], sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            check_now();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++) exp_range(s, 1, 9, 0, -1);
        run_to(2);
        rst = 1'b0;
        run_to(10);
        irq_raw[0] = 1'b1;
        irq_raw[1] = 1'b1;
        irq_raw[2] = 1'b1;
        exp_range(0, 10, 45, 16, 35);
        exp_range(1, 10, 199, 0, -1);
        exp_range(2, 10, 79, 17, 24);
        exp_range(3, 10, 119, 0, -1);
        run_to(13);
        irq_raw[1] = 1'b0;
        run_to(30);
        irq_raw[0] = 1'b0;
        exp_range(0, 46, 199, 0, -1);
        run_to(60);
        irq_raw[2] = 1'b0;
        run_to(80);
        irq_raw[2] = 1'b1;
        exp_range(2, 80, 199, 87, 102);
        run_to(84);
        irq_raw[2] = 1'b0;
        run_to(88);
        irq_raw[2] = 1'b1;
        run_to(110);
        irq_raw[2] = 1'b0;
        run_to(120);
        irq_raw[3] = 1'b1;
        exp_range(3, 120, 130, 127, 130);
        run_to(130);
        src_en[3] = 1'b0;
        exp_range(3, 131, 199, 157, 164);
        run_to(135);
        irq_raw[3] = 1'b0;
        run_to(150);
        src_en[3] = 1'b1;
        irq_raw[3] = 1'b1;
        run_to(170);
        irq_raw[3] = 1'b0;
        run_to(200);
        irq_raw = '1;
        exp_range(0, 200, END_CYC, 206, 209);
        exp_range(1, 200, END_CYC, 206, 209);
        exp_range(2, 200, END_CYC, 207, 209);
        exp_range(3, 200, END_CYC, 207, 209);
        run_to(205);
        irq_raw = '0;
        run_to(209);
        rst = 1'b1;
        run_to(210);
        rst = 1'b0;
        run_to(END_CYC);
        @(negedge clk);
        check_now();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
